// File: rtl/bram_burst_sequencer_if.sv
// Bus bundle for the burst sequencer: command, write/read streams and the BRAM controller side.
// The master modport is the sequencer; the slave modport is whatever surrounds it.
interface bram_burst_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
);
    logic                  i_start;
    logic                  i_mode;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [LEN_WIDTH-1:0]  i_len;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_timeout;
    logic [DATA_WIDTH-1:0] s_wdata;
    logic                  s_wvalid;
    logic                  s_wready;
    logic [DATA_WIDTH-1:0] m_rdata;
    logic                  m_rvalid;
    logic                  m_rready;
    logic                  ctrl_run;
    logic                  ctrl_mode;
    logic [ADDR_WIDTH-1:0] ctrl_addr;
    logic [DATA_WIDTH-1:0] ctrl_wdata;
    logic                  ctrl_idle;
    logic                  ctrl_done;
    logic                  ctrl_rvalid;
    logic [DATA_WIDTH-1:0] ctrl_rdata;

    modport master (
        input  i_start, i_mode, i_base_addr, i_len,
        input  s_wdata, s_wvalid, m_rready,
        input  ctrl_idle, ctrl_done, ctrl_rvalid, ctrl_rdata,
        output o_busy, o_done, o_timeout, s_wready, m_rdata, m_rvalid,
        output ctrl_run, ctrl_mode, ctrl_addr, ctrl_wdata
    );

    modport slave (
        output i_start, i_mode, i_base_addr, i_len,
        output s_wdata, s_wvalid, m_rready,
        output ctrl_idle, ctrl_done, ctrl_rvalid, ctrl_rdata,
        input  o_busy, o_done, o_timeout, s_wready, m_rdata, m_rvalid,
        input  ctrl_run, ctrl_mode, ctrl_addr, ctrl_wdata
    );
endinterface

// File: rtl/bram_burst_sequencer.sv
// Expands one burst command into single-word BRAM controller transactions.
// Define BRAM_SEQ_TIMEOUT_EN to add an 8-bit WAIT watchdog that aborts a stuck burst.
module bram_burst_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 11
) (
    input logic                    clk,
    input logic                    reset_n,
    bram_burst_sequencer_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
    logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
    logic                  seen_done_q, seen_done_d;
    logic                  ctrl_mode_q, ctrl_mode_d;
    logic [ADDR_WIDTH-1:0] ctrl_addr_q, ctrl_addr_d;
    logic [DATA_WIDTH-1:0] ctrl_wdata_q, ctrl_wdata_d;
    logic [DATA_WIDTH-1:0] m_rdata_q, m_rdata_d;
    logic                  m_rvalid_q, m_rvalid_d;
    logic                  o_busy_q, o_busy_d;
    logic                  o_done_q, o_done_d;
`ifdef BRAM_SEQ_TIMEOUT_EN
    logic [7:0]            wdog_q, wdog_d;
    logic                  o_timeout_q, o_timeout_d;
`endif

    logic rd_drain;
    logic fire;
    logic word_done;

    // A read may only be issued when its result has somewhere to land.
    assign rd_drain  = m_rvalid_q & bus.m_rready;
    assign fire      = (state_q == ISSUE) & bus.ctrl_idle &
                       (mode_q ? bus.s_wvalid : (~m_rvalid_q | rd_drain));
    assign word_done = (state_q == WAIT) &
                       (mode_q ? ((seen_done_q | bus.ctrl_done) & bus.ctrl_idle)
                               : bus.ctrl_rvalid);

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cur_addr_d   = cur_addr_q;
        remaining_d  = remaining_q;
        seen_done_d  = seen_done_q;
        ctrl_mode_d  = ctrl_mode_q;
        ctrl_addr_d  = ctrl_addr_q;
        ctrl_wdata_d = ctrl_wdata_q;
        m_rdata_d    = m_rdata_q;
        m_rvalid_d   = m_rvalid_q;
        o_done_d     = 1'b0;
`ifdef BRAM_SEQ_TIMEOUT_EN
        wdog_d       = wdog_q;
        o_timeout_d  = 1'b0;
`endif
        if (rd_drain) m_rvalid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    if (bus.i_len != '0) begin
                        mode_d      = bus.i_mode;
                        cur_addr_d  = bus.i_base_addr;
                        remaining_d = bus.i_len;
                        state_d     = ISSUE;
                    end else begin
                        state_d  = DONE;
                        o_done_d = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (fire) begin
                    ctrl_addr_d = cur_addr_q;
                    ctrl_mode_d = mode_q;
                    if (mode_q) ctrl_wdata_d = bus.s_wdata;
                    seen_done_d = 1'b0;
                    state_d     = WAIT;
`ifdef BRAM_SEQ_TIMEOUT_EN
                    wdog_d      = '0;
`endif
                end
            end
            WAIT: begin
                if (bus.ctrl_done) seen_done_d = 1'b1;
                if (word_done) begin
                    // Capture overlapping a drain keeps valid high with the new word.
                    if (!mode_q) begin
                        m_rdata_d  = bus.ctrl_rdata;
                        m_rvalid_d = 1'b1;
                    end
                    cur_addr_d  = cur_addr_q + ADDR_WIDTH'(1);
                    remaining_d = remaining_q - LEN_WIDTH'(1);
                    if (remaining_q == LEN_WIDTH'(1)) begin
                        state_d  = DONE;
                        o_done_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                    end
                end
`ifdef BRAM_SEQ_TIMEOUT_EN
                // wdog counts completed WAIT cycles; the 255th without progress aborts.
                else if (wdog_q == 8'd254) begin
                    state_d     = IDLE;
                    o_timeout_d = 1'b1;
                    cur_addr_d  = '0;
                    remaining_d = '0;
                    m_rvalid_d  = 1'b0;
                    m_rdata_d   = '0;
                end else begin
                    wdog_d = wdog_q + 8'd1;
                end
`endif
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        o_busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            mode_q       <= 1'b0;
            cur_addr_q   <= '0;
            remaining_q  <= '0;
            seen_done_q  <= 1'b0;
            ctrl_mode_q  <= 1'b0;
            ctrl_addr_q  <= '0;
            ctrl_wdata_q <= '0;
            m_rdata_q    <= '0;
            m_rvalid_q   <= 1'b0;
            o_busy_q     <= 1'b0;
            o_done_q     <= 1'b0;
`ifdef BRAM_SEQ_TIMEOUT_EN
            wdog_q       <= '0;
            o_timeout_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cur_addr_q   <= cur_addr_d;
            remaining_q  <= remaining_d;
            seen_done_q  <= seen_done_d;
            ctrl_mode_q  <= ctrl_mode_d;
            ctrl_addr_q  <= ctrl_addr_d;
            ctrl_wdata_q <= ctrl_wdata_d;
            m_rdata_q    <= m_rdata_d;
            m_rvalid_q   <= m_rvalid_d;
            o_busy_q     <= o_busy_d;
            o_done_q     <= o_done_d;
`ifdef BRAM_SEQ_TIMEOUT_EN
            wdog_q       <= wdog_d;
            o_timeout_q  <= o_timeout_d;
`endif
        end
    end

    assign bus.o_busy     = o_busy_q;
    assign bus.o_done     = o_done_q;
`ifdef BRAM_SEQ_TIMEOUT_EN
    assign bus.o_timeout  = o_timeout_q;
`else
    assign bus.o_timeout  = 1'b0;
`endif
    assign bus.ctrl_run   = fire;
    assign bus.s_wready   = fire & mode_q;
    assign bus.ctrl_mode  = ctrl_mode_q;
    assign bus.ctrl_addr  = ctrl_addr_q;
    assign bus.ctrl_wdata = ctrl_wdata_q;
    assign bus.m_rdata    = m_rdata_q;
    assign bus.m_rvalid   = m_rvalid_q;
endmodule

// File: tb/tb_bram_burst_sequencer.sv
// Scoreboard bench for bram_burst_sequencer: stimulus pushes expected transactions and
// read data from a reference memory; a cycle monitor with a BRAM controller model checks them.
module tb_bram_burst_sequencer;
    localparam int DW = 32, AW = 10, LW = 11, DEPTH = 1 << AW;

    typedef struct {
        logic          mode;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } run_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    bram_burst_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus();
    bram_burst_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    int n_chk = 0, n_fail = 0;
    run_t          exp_run_q[$];
    logic [DW-1:0] exp_rd_q[$];
    logic [DW-1:0] wsrc_q[$];
    logic [DW-1:0] ref_mem[DEPTH];
    logic [DW-1:0] bram[DEPTH];
    int run_idx = 0, rd_idx = 0, ws_idx = 0;
    int run_cnt = 0, done_cnt = 0, beat_cnt = 0, tmo_cnt = 0;
    int flush_gen = 0;
    int wv_mode = 0, rr_mode = 0;
    bit ctl_stuck = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    // Environment: controller model, write source, read sink and the output monitor.
    initial begin : env
        run_t          cur;
        bit            got_run;
        int            ph, cnt, flush_seen;
        logic          c_mode, held_v, have;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata, held_d;
        got_run = 0; ph = 0; cnt = 0; flush_seen = 0;
        c_mode = 0; c_addr = '0; c_wdata = '0; held_v = 0; held_d = '0;
        bus.ctrl_idle = 1'b1; bus.ctrl_done = 1'b0; bus.ctrl_rvalid = 1'b0; bus.ctrl_rdata = '0;
        bus.s_wvalid = 1'b0; bus.s_wdata = '0; bus.m_rready = 1'b0;
        forever begin
            @(negedge clk);
            if (got_run) begin
                got_run = 0;
                chk("run_addr", 64'(bus.ctrl_addr), 64'(cur.addr));
                chk("run_mode", 64'(bus.ctrl_mode), 64'(cur.mode));
                if (cur.mode) chk("run_wdata", 64'(bus.ctrl_wdata), 64'(cur.wdata));
                c_mode = bus.ctrl_mode; c_addr = bus.ctrl_addr; c_wdata = bus.ctrl_wdata;
                ph = ctl_stuck ? 3 : 1;
                cnt = $urandom_range(0, 2);
            end else if (ph == 1) begin
                if (cnt == 0) begin
                    ph = 2;
                    if (c_mode) bram[c_addr] = c_wdata;
                end else cnt--;
            end else if (ph == 2) ph = 0;
            bus.ctrl_idle   = (ph == 0);
            bus.ctrl_done   = (ph == 2);
            bus.ctrl_rvalid = (ph == 2) && !c_mode;
            bus.ctrl_rdata  = (ph == 2 && !c_mode) ? bram[c_addr] : $urandom;
            if (ws_idx < wsrc_q.size() && (wv_mode == 1 || $urandom_range(0, 3) != 0)) begin
                bus.s_wvalid = 1'b1; bus.s_wdata = wsrc_q[ws_idx];
            end else begin
                bus.s_wvalid = 1'b0; bus.s_wdata = $urandom;
            end
            bus.m_rready = (rr_mode == 1) ? 1'b1 : (rr_mode == 2) ? 1'b0 : ($urandom_range(0, 2) != 0);
            #2;
            if (flush_gen != flush_seen) begin
                // Abandoned burst: drop whatever it still owed.
                flush_seen = flush_gen;
                run_idx = exp_run_q.size(); rd_idx = exp_rd_q.size(); ws_idx = wsrc_q.size();
                got_run = 0; ph = 0; held_v = 0;
                bus.ctrl_idle = 1'b1; bus.ctrl_done = 1'b0; bus.ctrl_rvalid = 1'b0;
            end else begin
                if (bus.ctrl_run) begin
                    run_cnt++;
                    have = (run_idx < exp_run_q.size());
                    chk("run_expected", 64'(have), 64'(1));
                    if (have) begin
                        cur = exp_run_q[run_idx]; run_idx++; got_run = 1;
                        chk("run_wready", 64'(bus.s_wready), 64'(cur.mode));
                    end
                end
                if (bus.s_wready) begin
                    chk("wready_hs", 64'({bus.s_wvalid, bus.ctrl_run}), 64'(2'b11));
                    ws_idx++;
                end
                if (held_v) chk("rdata_hold", 64'({bus.m_rvalid, bus.m_rdata}), 64'({1'b1, held_d}));
                if (bus.m_rvalid && bus.m_rready) begin
                    beat_cnt++;
                    have = (rd_idx < exp_rd_q.size());
                    chk("beat_expected", 64'(have), 64'(1));
                    if (have) begin
                        chk("rdata", 64'(bus.m_rdata), 64'(exp_rd_q[rd_idx]));
                        rd_idx++;
                    end
                end
                held_v = bus.m_rvalid && !bus.m_rready;
                held_d = bus.m_rdata;
                if (bus.o_done) done_cnt++;
                if (bus.o_timeout) tmo_cnt++;
            end
        end
    end

    // Reference: a burst is len words at (base+i) mod 2^AW; writes update ref_mem,
    // reads return ref_mem contents at those addresses.
    task automatic burst(input bit mode, input int base, input int len, input bit rnd, input int dbase);
        for (int i = 0; i < len; i++) begin
            run_t r;
            int   a;
            a = (base + i) % DEPTH;
            r.mode = mode; r.addr = AW'(a); r.wdata = '0;
            if (mode) begin
                r.wdata = rnd ? DW'($urandom) : DW'(dbase + i);
                ref_mem[a] = r.wdata;
                wsrc_q.push_back(r.wdata);
            end else begin
                exp_rd_q.push_back(ref_mem[a]);
            end
            exp_run_q.push_back(r);
        end
        bus.i_mode = mode; bus.i_base_addr = AW'(base); bus.i_len = LW'(len);
        bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int d0, input int exp_done);
        int n;
        n = 0;
        while ((bus.o_busy || rd_idx < exp_rd_q.size()) && n < 3000) begin cyc(); n++; end
        chk({name, "_finish"}, 64'(n < 3000), 64'(1));
        chk({name, "_runs"}, 64'(run_idx), 64'(exp_run_q.size()));
        chk({name, "_done"}, 64'(done_cnt - d0), 64'(exp_done));
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_flags"}, 64'({bus.o_busy, bus.o_done, bus.o_timeout, bus.s_wready,
                                    bus.m_rvalid, bus.ctrl_run, bus.ctrl_mode}), 64'(0));
        chk({name, "_addr"}, 64'(bus.ctrl_addr), 64'(0));
        chk({name, "_wdata"}, 64'(bus.ctrl_wdata), 64'(0));
        chk({name, "_rdata"}, 64'(bus.m_rdata), 64'(0));
    endtask

    task automatic wait_first_run(input string name, input int r0);
        int n;
        n = 0;
        while (run_cnt == r0 && n < 200) begin cyc(); n++; end
        chk({name, "_first_run"}, 64'(n < 200), 64'(1));
    endtask

    initial begin : stim
        int d0, r0, w0, b0, n, base;
        bus.i_start = 1'b0; bus.i_mode = 1'b0; bus.i_base_addr = '0; bus.i_len = '0;
        for (int a = 0; a < DEPTH; a++) begin
            ref_mem[a] = DW'(a) * 32'h0001_0003 ^ 32'h5A00_0000;
            bram[a]    = ref_mem[a];
        end
        cyc(3);
        chk_zero("reset");
        reset_n = 1'b1;
        cyc(2);

        // Directed write then read-back, streams never stalling.
        wv_mode = 1; rr_mode = 1;
        d0 = done_cnt; w0 = ws_idx;
        burst(1'b1, 'h010, 4, 1'b0, 'hA0);
        wait_idle("wr4", d0, 1);
        chk("wr4_wready", 64'(ws_idx - w0), 64'(4));
        d0 = done_cnt; b0 = beat_cnt;
        burst(1'b0, 'h010, 4, 1'b0, 0);
        wait_idle("rd4", d0, 1);
        chk("rd4_beats", 64'(beat_cnt - b0), 64'(4));

        // Read sink stalled: nothing more may be issued while the first word is held.
        rr_mode = 2;
        d0 = done_cnt; r0 = run_cnt; b0 = beat_cnt;
        burst(1'b0, 'h123, 3, 1'b0, 0);
        n = 0;
        while (!bus.m_rvalid && n < 200) begin cyc(); n++; end
        chk("stall_first_beat", 64'(n < 200), 64'(1));
        cyc(20);
        chk("stall_runs", 64'(run_cnt - r0), 64'(1));
        chk("stall_valid", 64'(bus.m_rvalid), 64'(1));
        rr_mode = 1;
        wait_idle("stall", d0, 1);
        chk("stall_beats", 64'(beat_cnt - b0), 64'(3));

        // Address wrap, with a stray start while busy.
        d0 = done_cnt; r0 = run_cnt;
        burst(1'b1, 'h3FE, 3, 1'b1, 0);
        cyc(2);
        chk("wrap_busy", 64'(bus.o_busy), 64'(1));
        bus.i_mode = 1'b0; bus.i_base_addr = AW'(5); bus.i_len = LW'(5); bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        wait_idle("wrap", d0, 1);
        chk("wrap_run_count", 64'(run_cnt - r0), 64'(3));
        rr_mode = 0;
        d0 = done_cnt;
        burst(1'b0, 'h3FE, 3, 1'b0, 0);
        wait_idle("wrap_rd", d0, 1);

        // Zero-length burst.
        d0 = done_cnt; r0 = run_cnt;
        bus.i_mode = 1'b1; bus.i_base_addr = AW'(7); bus.i_len = '0; bus.i_start = 1'b1;
        cyc();
        bus.i_start = 1'b0;
        chk("len0_done", 64'({bus.o_done, bus.o_busy}), 64'(2'b11));
        cyc();
        chk("len0_after", 64'({bus.o_done, bus.o_busy}), 64'(0));
        chk("len0_runs", 64'(run_cnt - r0), 64'(0));
        chk("len0_done_cnt", 64'(done_cnt - d0), 64'(1));

        // Reset while a len-8 read is waiting on the controller.
        rr_mode = 1;
        d0 = done_cnt; r0 = run_cnt;
        burst(1'b0, 'h200, 8, 1'b0, 0);
        wait_first_run("rst", r0);
        reset_n = 1'b0;
        flush_gen++;
        cyc();
        chk_zero("mid_reset");
        cyc(4);
        chk("mid_reset_no_done", 64'(done_cnt - d0), 64'(0));
        reset_n = 1'b1;
        cyc(2);
        rr_mode = 0;
        d0 = done_cnt;
        burst(1'b0, 'h201, 5, 1'b0, 0);
        wait_idle("post_reset", d0, 1);

        // Randomized bursts.
        wv_mode = 0;
        for (int k = 0; k < 14; k++) begin
            d0 = done_cnt;
            base = $urandom_range(0, DEPTH - 1);
            burst(1'($urandom_range(0, 1)), base, $urandom_range(1, 12), 1'b1, 0);
            wait_idle("rand", d0, 1);
        end

`ifdef BRAM_SEQ_TIMEOUT_EN
        // Controller never finishes: watchdog must abort 255 WAIT cycles in.
        ctl_stuck = 1'b1; rr_mode = 1;
        d0 = done_cnt; r0 = run_cnt;
        burst(1'b0, 'h050, 2, 1'b0, 0);
        wait_first_run("tmo", r0);
        n = 1;
        while (!bus.o_timeout && n < 400) begin cyc(); n++; end
        chk("tmo_latency", 64'(n), 64'(256));
        chk("tmo_idle", 64'({bus.o_busy, bus.o_done, bus.m_rvalid}), 64'(0));
        cyc(2);
        chk("tmo_no_done", 64'(done_cnt - d0), 64'(0));
        chk("tmo_pulses", 64'(tmo_cnt), 64'(1));
        flush_gen++;
        ctl_stuck = 1'b0;
        cyc(2);
`else
        chk("no_timeout", 64'(tmo_cnt), 64'(0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation ran past its time bound");
        $fatal(1);
    end
endmodule

// File: doc/bram_burst_sequencer.md
Name: bram_burst_sequencer

Overview:
- Upstream stage of the single-port BRAM controller.
- Turns one burst command (base address, word count, mode) into a sequence of single-word controller transactions.
- Write bursts: sources write data from a valid/ready input stream.
- Read bursts: returns read data on a valid/ready output stream, with backpressure handled by a one-entry output register.

Parameters:
DATA_WIDTH, 32, word width; equals the controller data width
ADDR_WIDTH, 10, BRAM address width
LEN_WIDTH, 11, burst length width; a burst is 0 to 2^LEN_WIDTH-1 words

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
i_start  in  1  command strobe; sampled only in IDLE
i_mode  in  1  1 = write burst, 0 = read burst
i_base_addr  in  ADDR_WIDTH  first word address
i_len  in  LEN_WIDTH  number of words
o_busy  out  1  high in any state other than IDLE
o_done  out  1  one-cycle pulse at burst end
o_timeout  out  1  one-cycle pulse on watchdog abort (see Optional Feature)
s_wdata  in  DATA_WIDTH  write stream data
s_wvalid  in  1  write stream valid
s_wready  out  1  write stream ready; one-cycle pulse per accepted word
m_rdata  out  DATA_WIDTH  read stream data
m_rvalid  out  1  read stream valid
m_rready  in  1  read stream ready
ctrl_run  out  1  one-cycle run pulse to the controller
ctrl_mode  out  1  mode to the controller
ctrl_addr  out  ADDR_WIDTH  address to the controller; registered
ctrl_wdata  out  DATA_WIDTH  write data to the controller; registered
ctrl_idle  in  1  controller idle
ctrl_done  in  1  controller done state
ctrl_rvalid  in  1  controller read-data valid pulse
ctrl_rdata  in  DATA_WIDTH  controller read data

Behaviour:
- Reset values: all outputs and registers 0; state IDLE; any buffered read word is discarded. Reset mid-burst aborts the burst with no o_done.
- States: IDLE, ISSUE, WAIT, DONE.

IDLE
- i_start with i_len != 0: latch mode, base address and length into cur_addr, remaining; go to ISSUE.
- i_start with i_len == 0: go to DONE (o_done pulses the next cycle); no BRAM access.
- While o_busy=1, i_start is ignored.

ISSUE
- Fires when ctrl_idle=1 and either:
  - write mode: s_wvalid=1; or
  - read mode: output register empty, or being emptied this cycle (m_rvalid & m_rready).
- On fire:
  - ctrl_run=1 for this cycle.
  - ctrl_addr<=cur_addr, ctrl_mode<=mode.
  - Write mode only: s_wready=1 and ctrl_wdata<=s_wdata.
  - Clear seen_done; go to WAIT.
- ctrl_addr, ctrl_mode and ctrl_wdata stay stable from the fire cycle until the next fire.

WAIT
- seen_done is set on ctrl_done=1.
- Word complete:
  - write mode: seen_done=1 and ctrl_idle=1;
  - read mode: ctrl_rvalid=1, which also captures ctrl_rdata into m_rdata and sets m_rvalid.
- On completion: cur_addr<=cur_addr+1, wrapping modulo 2^ADDR_WIDTH (0x3FF -> 0x000); remaining<=remaining-1; if remaining==1 go to DONE, else go to ISSUE.

DONE
- o_done=1 for one cycle, then IDLE.
- For a read burst, the last word may still be held in m_rdata/m_rvalid after o_done; it is still delivered normally.

Read output register
- m_rvalid is cleared on m_rvalid & m_rready.
- Capture and drain in the same cycle leaves m_rvalid=1 with the new data.
- m_rdata holds its value while m_rvalid=1 and m_rready=0.

Throughput
- A word is in flight at most once, so nothing is ever overwritten.
- With no stalls, each word costs 1 ISSUE cycle plus the controller's transaction time.

Optional Feature:
- Macro: BRAM_SEQ_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog clears on entry to WAIT and counts each WAIT cycle.
  - At 255 cycles with no word completion: o_timeout pulses for one cycle, state goes to IDLE, and o_done is not asserted.
  - cur_addr, remaining and the output register are cleared.
- Not defined: no watchdog; o_timeout is tied to 0.

Test Plan:
- Write burst, base 0x010, len 4, data 0xA0..0xA3 with s_wvalid always 1 -> four ctrl_run pulses at addrs 0x010..0x013 carrying ctrl_wdata 0xA0..0xA3; exactly 4 s_wready pulses; one o_done.
- Read back base 0x010, len 4, m_rready=1 -> m_rdata 0xA0,0xA1,0xA2,0xA3 in order, one beat each; o_done once.
- Read len 3 with m_rready held 0 for 20 cycles after the first beat -> only one ctrl_run is issued in that window; m_rdata holds the first word; on release all 3 words arrive in order with none lost.
- Wrap: write base 0x3FE, len 3 -> addrs 0x3FE, 0x3FF, 0x000; i_start pulsed mid-burst is ignored.
- i_len=0 -> o_done pulses on the cycle after i_start; no ctrl_run. Separately, reset_n low during WAIT of a len-8 read -> all outputs 0, no o_done, and a fresh burst afterwards runs normally.
- With BRAM_SEQ_TIMEOUT_EN, ctrl_idle held 0 -> o_timeout pulses 255 cycles after entering WAIT, returns to IDLE, o_done stays 0.
